// File: rtl/jk_seq_exciter_if.sv
// Host/bank signal bundle for jk_seq_exciter: sequence programming, run control,
// status, and the J/K excitation plus Q feedback of the external JK bank.
interface jk_seq_exciter_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [AW:0]      len;
  logic             loop;
  logic             stop;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [7:0]       err_cnt;

  // Master is the host together with the JK bank; slave is the exciter.
  modport master (
    output wr_en, wr_addr, wr_data, start, len, loop, stop, q,
    input  j, k, busy, done, mismatch, err_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, loop, stop, q,
    output j, k, busy, done, mismatch, err_cnt
  );
endinterface

// File: rtl/jk_seq_exciter.sv
// Programmable J/K excitation generator stepping an external JK bank through a stored
// sequence and checking its Q feedback. Define JK_TOGGLE_EN for toggle-style encoding.
module jk_seq_exciter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  jk_seq_exciter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] seq_mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] exp;
  logic [AW:0]      len_r;
  logic             loop_r;
  logic             mismatch_r;
  logic [7:0]       err_cnt_r;
  logic [WIDTH-1:0] target;
  logic             last_step;
  logic             check_en;
  logic             diff;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Don't-care excitation bits resolve to 1 with toggling enabled, to 0 otherwise.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
`ifdef JK_TOGGLE_EN
    return cur | tgt;
`else
    return ~cur & tgt;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
`ifdef JK_TOGGLE_EN
    return ~(cur & tgt);
`else
    return cur & ~tgt;
`endif
  endfunction

  assign target    = seq_mem[idx];
  assign last_step = ({1'b0, idx} == (len_r - (AW+1)'(1)));
  assign check_en  = (state == RUN) || (state == DONE);
  assign diff      = (bus.q != exp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.len == '0) ? DONE : RUN;
      RUN:  if (bus.stop || (last_step && !loop_r)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    j_c = '0;
    k_c = '0;
    if (state == RUN) begin
      j_c = excite_j(exp, target);
      k_c = excite_k(exp, target);
    end
  end

  // Sequence storage: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.wr_en) seq_mem[bus.wr_addr] <= bus.wr_data;
  end

  // Step control and the feedback checker; the bank lags exp by one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      exp        <= '0;
      len_r      <= '0;
      loop_r     <= 1'b0;
      mismatch_r <= 1'b0;
      err_cnt_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp        <= bus.q;
            idx        <= '0;
            len_r      <= bus.len;
            loop_r     <= bus.loop;
            mismatch_r <= 1'b0;
            err_cnt_r  <= '0;
          end
        end
        RUN: begin
          exp <= target;
          idx <= last_step ? '0 : idx + AW'(1);
        end
        default: ;
      endcase
      if (check_en && diff) begin
        mismatch_r <= 1'b1;
        err_cnt_r  <= sat_inc(err_cnt_r);
      end
    end
  end

  assign bus.j        = j_c;
  assign bus.k        = k_c;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.mismatch = mismatch_r;
  assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_jk_seq_exciter.sv
// Directed bench for jk_seq_exciter: a JK bank model closes the loop, expected
// per-cycle observations are queued by the stimulus and checked by a monitor.
module tb_jk_seq_exciter;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic       mm;
    logic [7:0] err;
    logic       chk_jk;
    logic [3:0] j;
    logic [3:0] k;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  logic [3:0] bank_q;
  logic [3:0] stuck = 4'h0;
  logic [3:0] load_val = 4'h0;
  logic       load_en = 1'b0;

  always #5 clk = ~clk;

  jk_seq_exciter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  jk_seq_exciter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits; never reset.
  always @(posedge clk) begin
    if (load_en) bank_q <= load_val & ~stuck;
    else         bank_q <= ((bus.j & ~bank_q) | (~bus.k & bank_q)) & ~stuck;
  end
  assign bus.q = bank_q;

  function automatic void push(input logic b, input logic d, input logic [3:0] q,
                               input logic mm, input logic [7:0] err,
                               input logic chk, input logic [3:0] j, input logic [3:0] k);
    obs_t o;
    o.busy = b; o.done = d; o.q = q; o.mm = mm; o.err = err;
    o.chk_jk = chk; o.j = j; o.k = k;
    exp_q.push_back(o);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic load_bank(input logic [3:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [3:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic run(input logic [3:0] ln, input logic lp);
    bus.start = 1'b1; bus.len = ln; bus.loop = lp;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Monitor: every cycle the DUT shows busy or done, pop and compare one observation.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (rst && (bus.busy || bus.done)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: unexpected busy=%0d done=%0d q=%h", bus.busy, bus.done, bus.q);
        end else begin
          e = exp_q.pop_front();
          if (bus.busy !== e.busy || bus.done !== e.done || bus.q !== e.q ||
              bus.mismatch !== e.mm || bus.err_cnt !== e.err ||
              (e.chk_jk && (bus.j !== e.j || bus.k !== e.k))) begin
            errors++;
            $display("FAIL sb_step: got busy=%0d done=%0d q=%h mm=%0d err=%0d j=%h k=%h, expected busy=%0d done=%0d q=%h mm=%0d err=%0d j=%h k=%h (jk checked %0d)",
                     bus.busy, bus.done, bus.q, bus.mismatch, bus.err_cnt, bus.j, bus.k,
                     e.busy, e.done, e.q, e.mm, e.err, e.j, e.k, e.chk_jk);
          end
        end
`ifndef JK_TOGGLE_EN
        checks++;
        if ((bus.j & bus.k) != 4'h0) begin
          errors++;
          $display("FAIL jk_both_high: j=%h k=%h, expected no bit with J=K=1", bus.j, bus.k);
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.len = '0; bus.loop = 1'b0; bus.stop = 1'b0;
    #2 rst = 1'b0;
    load_bank(4'h0);
    @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_j", bus.j, 0);
    check("rst_k", bus.k, 0);
    check("rst_mismatch", bus.mismatch, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Sequence 1,2,3,4 from 0; entry 0 written in the start cycle.
    write(3'd0, 4'h9); write(3'd1, 4'h2); write(3'd2, 4'h3); write(3'd3, 4'h4);
`ifdef JK_TOGGLE_EN
    push(1, 0, 4'h0, 0, 0, 1, 4'h1, 4'hF);
    push(1, 0, 4'h1, 0, 0, 1, 4'h3, 4'hF);
    push(1, 0, 4'h2, 0, 0, 1, 4'h3, 4'hD);
    push(1, 0, 4'h3, 0, 0, 1, 4'h7, 4'hF);
`else
    push(1, 0, 4'h0, 0, 0, 1, 4'h1, 4'h0);
    push(1, 0, 4'h1, 0, 0, 1, 4'h2, 4'h1);
    push(1, 0, 4'h2, 0, 0, 1, 4'h1, 4'h0);
    push(1, 0, 4'h3, 0, 0, 1, 4'h4, 4'h3);
`endif
    push(0, 1, 4'h4, 0, 0, 1, 4'h0, 4'h0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h1;
    run(4'd4, 1'b0);
    bus.wr_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("seq_final_q", bus.q, 4'h4);
    check("seq_idle_busy", bus.busy, 0);
    check("seq_mismatch", bus.mismatch, 0);

    // Bit 2 stuck at 0 with 4,4,4; a start during RUN must be ignored.
    stuck = 4'b0100;
    load_bank(4'h0);
    write(3'd0, 4'h4); write(3'd1, 4'h4); write(3'd2, 4'h4);
    push(1, 0, 4'h0, 0, 8'd0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h0, 0, 8'd0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h0, 1, 8'd1, 0, 4'h0, 4'h0);
    push(0, 1, 4'h0, 1, 8'd2, 0, 4'h0, 4'h0);
    run(4'd3, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b1; bus.len = 4'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stuck_mismatch", bus.mismatch, 1);
    check("stuck_err_cnt", bus.err_cnt, 3);
    repeat (3) @(posedge clk);
    #1;
    check("stuck_err_hold", bus.err_cnt, 3);

    // Asynchronous reset in the middle of a run.
    load_bank(4'h0);
    push(1, 0, 4'h0, 0, 8'd0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h0, 0, 8'd0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h0, 1, 8'd1, 0, 4'h0, 4'h0);
    run(4'd3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_j", bus.j, 0);
    check("midrst_k", bus.k, 0);
    check("midrst_err_cnt", bus.err_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 stuck = 4'h0;

    // Looping 5,A run, stopped after six busy cycles.
    load_bank(4'h0);
    write(3'd0, 4'h5); write(3'd1, 4'hA);
    push(1, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h5, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'hA, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h5, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'hA, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h5, 0, 0, 0, 4'h0, 4'h0);
    push(0, 1, 4'hA, 0, 0, 1, 4'h0, 4'h0);
    run(4'd2, 1'b1);
    repeat (5) @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("loop_final_q", bus.q, 4'hA);
    check("loop_idle_busy", bus.busy, 0);
    check("loop_err_cnt", bus.err_cnt, 0);

    // Writes during RUN/DONE must not reach the memory; rerun to prove it.
    push(1, 0, 4'hA, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h5, 0, 0, 0, 4'h0, 4'h0);
    push(0, 1, 4'hA, 0, 0, 0, 4'h0, 4'h0);
    run(4'd2, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'hF;
    @(posedge clk);
    #1 bus.wr_addr = 3'd0;
    @(posedge clk);
    #1 bus.wr_addr = 3'd1; bus.wr_data = 4'h3;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(1, 0, 4'hA, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 4'h5, 0, 0, 0, 4'h0, 4'h0);
    push(0, 1, 4'hA, 0, 0, 0, 4'h0, 4'h0);
    run(4'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rerun_final_q", bus.q, 4'hA);
    check("rerun_mismatch", bus.mismatch, 0);

    // len=0: done pulse straight away, never busy.
    push(0, 1, 4'hA, 0, 0, 1, 4'h0, 4'h0);
    run(4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("len0_done_cleared", bus.done, 0);
    check("len0_busy", bus.busy, 0);

    check("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
